// File: rtl/bfly_input_buffer.sv
// bfly_input_buffer: input-port stage of a 2x2 butterfly switch element.
// Queues single-flit packets in a small FIFO, routes the head flit by one
// destination bit to one of two output arbiters, and launches it on grant.
// Optional build macro: BFLY_IBUF_STATS_EN adds sent_cnt / stall_cnt outputs.
module bfly_input_buffer #(
   parameter int unsigned FLIT_W    = 16,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ROUTE_BIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   output logic              in_ready,
   output logic              req0,
   output logic              req1,
   input  logic              gnt0,
   input  logic              gnt1,
   output logic              out_valid,
   output logic              out_port,
   output logic [FLIT_W-1:0] out_flit
`ifdef BFLY_IBUF_STATS_EN
   ,
   output logic [15:0]       sent_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SEND    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [FLIT_W-1:0] head;
   logic              push;
   logic              pop;
   logic              gnt_sel;
   logic              sel;
   state_t            state;

   assign in_ready = (count != CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;
   assign head     = mem[rd_ptr];
   assign gnt_sel  = sel ? gnt1 : gnt0;
   // The head leaves the FIFO on the edge the selected grant is seen in REQ
   assign pop      = (state == REQ) && gnt_sel;

   // FIFO storage; data needs no reset since only occupied slots are read
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_flit;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Request/grant handshake FSM with registered req and launch outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= 1'b0;
         req0      <= 1'b0;
         req1      <= 1'b0;
         out_valid <= 1'b0;
         out_port  <= 1'b0;
         out_flit  <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  sel   <= head[ROUTE_BIT];
                  req0  <= ~head[ROUTE_BIT];
                  req1  <= head[ROUTE_BIT];
                  state <= REQ;
               end
            end
            REQ: begin
               if (gnt_sel) begin
                  out_valid <= 1'b1;
                  out_flit  <= head;
                  out_port  <= sel;
                  req0      <= 1'b0;
                  req1      <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               state <= RELEASE;
            end
            RELEASE: begin
               // Wait out the arbiter's lagging grant so it is not reused
               req0 <= 1'b0;
               req1 <= 1'b0;
               if (!gnt_sel) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef BFLY_IBUF_STATS_EN
   // Launch counter (wrapping) and grant-wait counter (saturating)
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop) begin
            sent_cnt <= sent_cnt + 16'd1;
         end
         if ((state == REQ) && !gnt_sel && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bfly_input_buffer.sv
// Testbench for bfly_input_buffer: queue-based reference model plus a
// delay-line arbiter model (grant = request delayed two cycles).
module tb_bfly_input_buffer;

   localparam int unsigned FLIT_W    = 16;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned ROUTE_BIT = 0;

   logic              clk      = 1'b0;
   logic              rst      = 1'b1;
   logic              in_valid = 1'b0;
   logic [FLIT_W-1:0] in_flit  = '0;
   logic              in_ready;
   logic              req0, req1, gnt0, gnt1;
   logic              out_valid, out_port;
   logic [FLIT_W-1:0] out_flit;
`ifdef BFLY_IBUF_STATS_EN
   logic [15:0]       sent_cnt, stall_cnt;
`endif

   bfly_input_buffer #(
      .FLIT_W(FLIT_W), .DEPTH(DEPTH), .ROUTE_BIT(ROUTE_BIT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
      .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .out_valid(out_valid), .out_port(out_port), .out_flit(out_flit)
`ifdef BFLY_IBUF_STATS_EN
      , .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Arbiter model: two register stages from request to grant, optional
   // two-cycle grant stretch, grant blocking and spurious grant forcing.
   logic a0 = 0, a1 = 0, q0 = 0, q1 = 0;
   logic s0a = 0, s0b = 0, s1a = 0, s1b = 0;
   logic blk0 = 0, frc1 = 0, stretch = 0;
   always @(posedge clk) begin
      a0 <= req0;  a1 <= req1;
      q0 <= a0;    q1 <= a1;
      s0a <= q0;   s0b <= s0a;
      s1a <= q1;   s1b <= s1a;
   end
   assign gnt0 = (q0 | (stretch & (s0a | s0b))) & ~blk0;
   assign gnt1 = (q1 | (stretch & (s1a | s1b))) | frc1;

   int n_tests  = 0;
   int n_fail   = 0;
   int ov_total = 0;
   logic [FLIT_W-1:0] mq[$];
   logic mon_en = 0;
   logic pg0 = 0, pg1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO order, routing bit, occupancy-derived in_ready
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid) begin
            ov_total++;
            chk("ov_has_flit", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) begin
               chk("ov_flit", 32'(out_flit), 32'(mq[0]));
               chk("ov_port", 32'(out_port), 32'(mq[0][ROUTE_BIT]));
               chk("ov_after_gnt", 32'(out_port ? pg1 : pg0), 32'd1);
               void'(mq.pop_front());
            end
         end
         chk("req_onehot", 32'(req0 & req1), 32'd0);
         chk("in_ready", 32'(in_ready), 32'(mq.size() != int'(DEPTH)));
         if (rst) mq.delete();
         else if (in_valid && mq.size() != int'(DEPTH)) mq.push_back(in_flit);
         pg0 = gnt0;
         pg1 = gnt1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_ov(input string name);
      int k;
      k = 0;
      while (!out_valid && k < 60) begin
         tick();
         k++;
      end
      chk({name, "_ov_timeout"}, 32'(out_valid), 32'd1);
   endtask

   int base;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_req0", 32'(req0), 32'd0);
      chk("rst_req1", 32'(req1), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_port", 32'(out_port), 32'd0);
      chk("rst_out_flit", 32'(out_flit), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      mon_en = 1'b1;

      // Single flit latency: req0 at cycle 2, launch at cycle 5
      do_reset();
      in_valid = 1'b1; in_flit = 16'h1234;           // cycle 0
      tick(); in_valid = 1'b0;                       // cycle 1
      chk("t1_req0_c1", 32'(req0), 32'd0);
      tick();                                        // cycle 2
      chk("t1_req0_c2", 32'(req0), 32'd1);
      chk("t1_req1_c2", 32'(req1), 32'd0);
      tick(); tick();                                // cycle 4
      chk("t1_ov_c4", 32'(out_valid), 32'd0);
      chk("t1_req1_c4", 32'(req1), 32'd0);
      tick();                                        // cycle 5
      chk("t1_ov_c5", 32'(out_valid), 32'd1);
      chk("t1_port_c5", 32'(out_port), 32'd0);
      chk("t1_flit_c5", 32'(out_flit), 32'h1234);
      repeat (8) tick();

      // Fill past depth with grant blocked, then release
      do_reset();
      blk0 = 1'b1;
      base = ov_total;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_flit  = 16'((i + 1) * 16);
         if (i == 3) chk("t2_ready_c3", 32'(in_ready), 32'd1);
         if (i == 4) chk("t2_full_c4", 32'(in_ready), 32'd0);
         tick();
      end
      repeat (3) tick();
      chk("t2_held", 32'(in_ready), 32'd0);
      chk("t2_no_ov", 32'(out_valid), 32'd0);
      blk0 = 1'b0;
      wait_ov("t2");
      chk("t2_first_flit", 32'(out_flit), 32'h0010);
      chk("t2_ready_after_send", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      repeat (50) tick();
      chk("t2_total_sent", 32'(ov_total - base), 32'd5);

      // Mixed routing with stretched grants: ports 1,0,1, no duplicates
      do_reset();
      stretch = 1'b1;
      base = ov_total;
      in_valid = 1'b1; in_flit = 16'h0001; tick();
      in_flit = 16'h0000; tick();
      in_flit = 16'h0003; tick();
      in_valid = 1'b0;
      wait_ov("t3a");
      chk("t3a_port", 32'(out_port), 32'd1);
      chk("t3a_flit", 32'(out_flit), 32'h0001);
      tick();
      wait_ov("t3b");
      chk("t3b_port", 32'(out_port), 32'd0);
      chk("t3b_flit", 32'(out_flit), 32'h0000);
      tick();
      wait_ov("t3c");
      chk("t3c_port", 32'(out_port), 32'd1);
      chk("t3c_flit", 32'(out_flit), 32'h0003);
      repeat (25) tick();
      chk("t3_total_sent", 32'(ov_total - base), 32'd3);
      stretch = 1'b0;

      // Grant withheld for 10 cycles in REQ
      do_reset();
      blk0 = 1'b1;
      in_valid = 1'b1; in_flit = 16'h0002;           // cycle 0
      tick(); in_valid = 1'b0;                       // cycle 1
      tick();                                        // cycle 2
      chk("t4_req0_c2", 32'(req0), 32'd1);
      for (int i = 0; i < 9; i++) begin              // cycles 3..11
         tick();
         chk("t4_req0_hold", 32'(req0), 32'd1);
         chk("t4_no_ov", 32'(out_valid), 32'd0);
      end
      tick();                                        // cycle 12
`ifdef BFLY_IBUF_STATS_EN
      chk("t4_stall_cnt", 32'(stall_cnt), 32'd10);
      chk("t4_sent_before", 32'(sent_cnt), 32'd0);
`endif
      blk0 = 1'b0;
      tick();                                        // cycle 13
      chk("t4_ov", 32'(out_valid), 32'd1);
      chk("t4_flit", 32'(out_flit), 32'h0002);
`ifdef BFLY_IBUF_STATS_EN
      chk("t4_sent_cnt", 32'(sent_cnt), 32'd1);
      chk("t4_stall_final", 32'(stall_cnt), 32'd10);
`endif
      repeat (8) tick();

      // Reset during RELEASE with two flits still queued
      do_reset();
      in_valid = 1'b1; in_flit = 16'h0100; tick();
      in_flit = 16'h0200; tick();
      in_flit = 16'h0300; tick();
      in_valid = 1'b0;
      wait_ov("t5");
      chk("t5_flit", 32'(out_flit), 32'h0100);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_req0", 32'(req0), 32'd0);
      chk("t5_req1", 32'(req1), 32'd0);
      chk("t5_ov", 32'(out_valid), 32'd0);
      chk("t5_ready", 32'(in_ready), 32'd1);
      base = ov_total;
      repeat (20) tick();
      chk("t5_no_more_ov", 32'(ov_total - base), 32'd0);

      // Spurious grant in IDLE with an empty FIFO
      do_reset();
      frc1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_no_ov", 32'(out_valid), 32'd0);
         chk("t6_ready", 32'(in_ready), 32'd1);
         chk("t6_no_req1", 32'(req1), 32'd0);
      end
      frc1 = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
